// File: rtl/key_event_pkg.sv
// Shared types and defaults for the key_event press classifier.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    LONG = 2'd2
  } state_t;

  localparam int unsigned LONG_CYC_DEF   = 500;
  localparam int unsigned REPEAT_CYC_DEF = 100;

  // Larger of two thresholds; sizes the shared sample counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_edge.sv
// key_edge: registers the filtered level and derives rise/fall strobes.
// y_d resets high so a level already high at reset release is not a press.
module key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic y,
  output logic rise_c,
  output logic fall_c
);

  logic y_d;

  // Previous-sample register, reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_d <= 1'b1;
    else        y_d <= y;
  end

  assign rise_c = y & ~y_d;
  assign fall_c = ~y & y_d;

endmodule

// File: rtl/key_event_edge.sv
// Edge detection for key_event is provided by module key_edge in key_edge.sv;
// this file is kept empty so existing file lists continue to build.

// File: rtl/key_event.sv
// key_event: classifies presses on a filtered key level into short/long
// pulses with an optional auto-repeat pulse during a long hold.
// Optional feature macro: KEY_EVENT_REPEAT_EN (enables rpt_p).
module key_event
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_CYC   = LONG_CYC_DEF,
  parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       y,
  output logic       short_p,
  output logic       long_p,
  output logic       rpt_p,
  output logic       held,
  output logic [7:0] press_cnt
);

  localparam int unsigned CW = $clog2(max_u(LONG_CYC, REPEAT_CYC) + 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          rise_c, fall_c;
  logic          short_n, long_n;
`ifdef KEY_EVENT_REPEAT_EN
  logic          rpt_n;
`endif

  key_edge u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .y      (y),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  assign cnt_inc = cnt + CW'(1);

  // State and sample-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state, counter and pulse decode.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    short_n = 1'b0;
    long_n  = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
    rpt_n   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rise_c) begin
          state_n = HOLD;
          cnt_n   = CW'(1);
        end
      end
      HOLD: begin
        if (fall_c) begin
          state_n = IDLE;
          short_n = 1'b1;
          cnt_n   = '0;
        end else if (y) begin
          if (cnt_inc == CW'(LONG_CYC)) begin
            state_n = LONG;
            long_n  = 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      LONG: begin
        if (fall_c) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
`ifdef KEY_EVENT_REPEAT_EN
        else if (y) begin
          if (cnt_inc == CW'(REPEAT_CYC)) begin
            rpt_n = 1'b1;
            cnt_n = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
`endif
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Registered pulses, held flag and press counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      short_p   <= 1'b0;
      long_p    <= 1'b0;
      held      <= 1'b0;
      press_cnt <= '0;
    end else begin
      short_p   <= short_n;
      long_p    <= long_n;
      held      <= (state_n != IDLE);
      press_cnt <= press_cnt + 8'(short_n | long_n);
    end
  end

`ifdef KEY_EVENT_REPEAT_EN
  // Registered auto-repeat pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rpt_p <= 1'b0;
    else        rpt_p <= rpt_n;
  end
`else
  assign rpt_p = 1'b0;
`endif

endmodule

// File: tb/tb_key_event.sv
// Scoreboard bench for key_event (LONG_CYC=5, REPEAT_CYC=3).
module tb_key_event;

  localparam int L = 5;
  localparam int R = 3;
  localparam int K_SHORT = 0;
  localparam int K_LONG  = 1;
  localparam int K_RPT   = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       y = 1'b0;
  logic       short_p, long_p, rpt_p, held;
  logic [7:0] press_cnt;

  key_event #(.LONG_CYC(L), .REPEAT_CYC(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .y         (y),
    .short_p   (short_p),
    .long_p    (long_p),
    .rpt_p     (rpt_p),
    .held      (held),
    .press_cnt (press_cnt)
  );

  always #5 clk = ~clk;

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  mon_cnt = 0;
  int  h_start = 0;
  int  h_end = 0;
  bit  chk_en = 1'b0;
  ev_t q[$];
  ev_t ev;
  int  es, el, er, eh;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Model: a press of n high samples, first sampled at edge k, yields events
  // visible after edge k+s-1 for the sample s that triggers them.
  task automatic press(input int n, input int gap);
    int k;
    @(negedge clk);
    y = 1'b1;
    k = cyc + 1;
    h_start = k;
    h_end   = k + n;
    if (n < L) begin
      q.push_back('{K_SHORT, k + n});
    end else begin
      q.push_back('{K_LONG, k + L - 1});
`ifdef KEY_EVENT_REPEAT_EN
      for (int s = L + R; s <= n; s += R) q.push_back('{K_RPT, k + s - 1});
`endif
    end
    repeat (n) @(negedge clk);
    y = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    mon_cnt = 0;
    h_end = 0;
    #1;
    chk("rst_short", int'(short_p), 0);
    chk("rst_long", int'(long_p), 0);
    chk("rst_rpt", int'(rpt_p), 0);
    chk("rst_held", int'(held), 0);
    chk("rst_cnt", int'(press_cnt), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: retire due events and compare every output each cycle.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      es = 0; el = 0; er = 0;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("event_missed", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        ev = q.pop_front();
        case (ev.kind)
          K_SHORT: es = 1;
          K_LONG:  el = 1;
          default: er = 1;
        endcase
        if (ev.kind != K_RPT) mon_cnt = (mon_cnt + 1) % 256;
      end
      eh = (cyc >= h_start && cyc < h_end) ? 1 : 0;
      chk("short_p", int'(short_p), es);
      chk("long_p", int'(long_p), el);
      chk("rpt_p", int'(rpt_p), er);
      chk("press_cnt", int'(press_cnt), mon_cnt);
      chk("held", int'(held), eh);
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("init_short", int'(short_p), 0);
    chk("init_long", int'(long_p), 0);
    chk("init_rpt", int'(rpt_p), 0);
    chk("init_held", int'(held), 0);
    chk("init_cnt", int'(press_cnt), 0);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    press(3, 2);
    press(12, 2);
    press(5, 2);
    press(4, 1);
    press(1, 1);
    press(6, 3);
    for (int i = 0; i < 25; i++) press(int'($urandom_range(1, 14)), int'($urandom_range(1, 4)));
    repeat (3) @(negedge clk);

    // Reset in the middle of a press, keeping y high through release.
    @(negedge clk);
    y = 1'b1;
    h_start = cyc + 1;
    h_end   = cyc + 100;
    repeat (2) @(negedge clk);
    do_reset();
    repeat (4) @(negedge clk);
    y = 1'b0;
    press(2, 2);
    repeat (3) @(negedge clk);

    // Press-count wrap.
    do_reset();
    for (int i = 0; i < 256; i++) press(int'($urandom_range(1, 4)), 1);
    repeat (4) @(negedge clk);
    chk("cnt_wrap", int'(press_cnt), 0);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
